// File: rtl/framebuffer_write_arbiter_if.sv
// Framebuffer write arbiter bus: two pixel requesters (pix, host) and the framebuffer write port.
// The arbiter connects through the slave modport; the requesters/framebuffer side uses master.
interface framebuffer_write_arbiter_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [18:0] pix_address;
  logic [7:0]  pix_data;
  logic        host_valid;
  logic        host_ready;
  logic [18:0] host_address;
  logic [7:0]  host_data;
  logic        fb_write_signal;
  logic [18:0] fb_write_address;
  logic [7:0]  fb_write_data;

  modport master (
    output pix_valid, pix_address, pix_data,
    output host_valid, host_address, host_data,
    input  pix_ready, host_ready,
    input  fb_write_signal, fb_write_address, fb_write_data
  );

  modport slave (
    input  pix_valid, pix_address, pix_data,
    input  host_valid, host_address, host_data,
    output pix_ready, host_ready,
    output fb_write_signal, fb_write_address, fb_write_data
  );
endinterface

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port with paced one-cycle write pulses.
// Optional fill engine enabled by defining FB_ARB_FILL_EN.
module framebuffer_write_arbiter #(
  parameter int unsigned FB_WORDS = 307200,
  parameter int unsigned DROP_W   = 8
) (
  input  logic                      fpga_clock,
  input  logic                      iRST_n,
  framebuffer_write_arbiter_if.slave bus,
  input  logic                      fill_start,
  input  logic [7:0]                fill_color,
  output logic                      fill_busy,
  output logic                      fill_done,
  output logic [DROP_W-1:0]         drop_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StFillIssue, StFillGap} state_e;

  state_e            state_q, state_d;
  logic              last_host_q, last_host_d;  // 1: host won the previous grant
  logic [18:0]       addr_q, addr_d;            // also serves as the fill counter
  logic [7:0]        data_q, data_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic        fill_go;
  logic        fill_last;
  logic        pix_ready_c, host_ready_c;
  logic        pix_acc, host_acc;
  logic [18:0] sel_addr;
  logic [7:0]  sel_data;

  assign fill_last = (state_q == StFillGap) && (32'(addr_q) == FB_WORDS - 1);

`ifdef FB_ARB_FILL_EN
  assign fill_go   = fill_start;
  assign fill_busy = (state_q == StFillIssue) || (state_q == StFillGap);
  assign fill_done = fill_last;
`else
  logic unused_fill;
  assign fill_go     = 1'b0;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign unused_fill = ^{fill_start, fill_last};
`endif

  always_comb begin
    state_d      = state_q;
    last_host_d  = last_host_q;
    addr_d       = addr_q;
    data_d       = data_q;
    drop_d       = drop_q;
    pix_ready_c  = 1'b0;
    host_ready_c = 1'b0;
    pix_acc      = 1'b0;
    host_acc     = 1'b0;
    sel_addr     = bus.pix_address;
    sel_data     = bus.pix_data;

    unique case (state_q)
      StIdle: begin
        if (fill_go) begin
          state_d = StFillIssue;
          addr_d  = '0;
          data_d  = fill_color;
        end else begin
          // A ready never looks at its own valid; ties go to the side not granted last.
          pix_ready_c  = iRST_n && (!bus.host_valid || last_host_q);
          host_ready_c = iRST_n && (!bus.pix_valid || !last_host_q);
          pix_acc      = bus.pix_valid && pix_ready_c;
          host_acc     = bus.host_valid && host_ready_c;
          if (host_acc) begin
            sel_addr = bus.host_address;
            sel_data = bus.host_data;
          end
          if (pix_acc || host_acc) begin
            last_host_d = host_acc;
            if (32'(sel_addr) < FB_WORDS) begin
              state_d = StIssue;
              addr_d  = sel_addr;
              data_d  = sel_data;
            end else if (drop_q != '1) begin
              drop_d = drop_q + 1'b1;
            end
          end
        end
      end
      StIssue:     state_d = StIdle;
      StFillIssue: state_d = StFillGap;
      StFillGap: begin
        if (fill_last) begin
          state_d = StIdle;
        end else begin
          state_d = StFillIssue;
          addr_d  = addr_q + 19'd1;
        end
      end
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge fpga_clock) begin
    if (!iRST_n) begin
      state_q     <= StIdle;
      last_host_q <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_host_q <= last_host_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.pix_ready        = pix_ready_c;
  assign bus.host_ready       = host_ready_c;
  assign bus.fb_write_signal  = (state_q == StIssue) || (state_q == StFillIssue);
  assign bus.fb_write_address = addr_q;
  assign bus.fb_write_data    = data_q;
  assign drop_count           = drop_q;

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Self-checking bench for framebuffer_write_arbiter: directed steps plus a randomized
// two-requester phase checked against a rule-level model. Fill tests need FB_ARB_FILL_EN.
module tb_framebuffer_write_arbiter;
  localparam int unsigned FbWords = 32;
  localparam int unsigned DropW   = 8;
  localparam int unsigned NTxn    = 12;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             fill_start = 1'b0;
  logic [7:0]       fill_color = 8'h00;
  logic             fill_busy;
  logic             fill_done;
  logic [DropW-1:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  framebuffer_write_arbiter_if bus ();

  framebuffer_write_arbiter #(
    .FB_WORDS(FbWords),
    .DROP_W  (DropW)
  ) dut (
    .fpga_clock(clk),
    .iRST_n    (rst_n),
    .bus       (bus.slave),
    .fill_start(fill_start),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n          = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.host_valid = 1'b0;
    fill_start     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [18:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 19'(FbWords - 1);
      1:       return 19'(FbWords + $urandom_range(0, 3));
      default: return 19'($urandom_range(0, FbWords - 1));
    endcase
  endfunction

  logic [18:0] pa[NTxn];
  logic [18:0] ha[NTxn];
  logic [7:0]  pd[NTxn];
  logic [7:0]  hd[NTxn];
  int          pi, hi, nw, last_cyc, drops, busy_n, done_n, fidx, viol, n5;
  logic        p_acc, h_acc, prev_wr, got_pix, seen, exp_wr, last_host;
  logic [18:0] exp_addr, a;
  logic [7:0]  exp_data, d;

  initial begin
    bus.pix_valid    = 1'b0;
    bus.host_valid   = 1'b0;
    bus.pix_address  = '0;
    bus.pix_data     = '0;
    bus.host_address = '0;
    bus.host_data    = '0;
    repeat (3) tick();

    // Reset state; readys forced low even with both valids high.
    bus.pix_valid  = 1'b1;
    bus.host_valid = 1'b1;
    #1;
    check("rst_pix_ready", bus.pix_ready, 0);
    check("rst_host_ready", bus.host_ready, 0);
    check("rst_wr", bus.fb_write_signal, 0);
    check("rst_addr", bus.fb_write_address, 0);
    check("rst_data", bus.fb_write_data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", fill_busy, 0);
    check("rst_done", fill_done, 0);
    bus.pix_valid  = 1'b0;
    bus.host_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single pix write.
    bus.pix_address = 19'h00010;
    bus.pix_data    = 8'hE3;
    bus.pix_valid   = 1'b1;
    #1;
    check("single_ready", bus.pix_ready, 1);
    tick();
    bus.pix_valid = 1'b0;
    check("single_wr", bus.fb_write_signal, 1);
    check("single_addr", bus.fb_write_address, 32'h10);
    check("single_data", bus.fb_write_data, 32'hE3);
    #1;
    check("single_issue_ready", bus.pix_ready, 0);
    tick();
    check("single_gap_wr", bus.fb_write_signal, 0);
    check("single_hold_addr", bus.fb_write_address, 32'h10);
    #1;
    check("single_ready_again", bus.pix_ready, 1);

    // Both requesters held valid: pix, host, pix, ... every 2 cycles.
    pulse_reset();
    pi = 0; hi = 0; nw = 0; last_cyc = 0; prev_wr = 1'b0;
    bus.pix_address  = 19'(pi);
    bus.pix_data     = 8'(8'hA0 + pi);
    bus.host_address = 19'(16 + hi);
    bus.host_data    = 8'(8'h50 + hi);
    bus.pix_valid    = 1'b1;
    bus.host_valid   = 1'b1;
    #1;
    p_acc = bus.pix_ready;
    h_acc = bus.host_ready;
    for (int c = 0; c < 40 && nw < 8; c++) begin
      tick();
      if (p_acc) pi++;
      if (h_acc) hi++;
      bus.pix_address  = 19'(pi);
      bus.pix_data     = 8'(8'hA0 + pi);
      bus.host_address = 19'(16 + hi);
      bus.host_data    = 8'(8'h50 + hi);
      if (bus.fb_write_signal) begin
        check("alt_addr", bus.fb_write_address, (nw % 2 == 0) ? nw / 2 : 16 + nw / 2);
        check("alt_data", bus.fb_write_data, (nw % 2 == 0) ? 8'hA0 + nw / 2 : 8'h50 + nw / 2);
        check("alt_no_b2b", prev_wr, 0);
        if (nw > 0) check("alt_spacing", c - last_cyc, 2);
        last_cyc = c;
        nw++;
      end
      prev_wr = bus.fb_write_signal;
      #1;
      p_acc = bus.pix_valid && bus.pix_ready;
      h_acc = bus.host_valid && bus.host_ready;
    end
    check("alt_count", nw, 8);
    bus.pix_valid  = 1'b0;
    bus.host_valid = 1'b0;
    tick();

    // Out-of-range requests are dropped and counted, saturating.
    bus.host_address = 19'h4B000;
    bus.host_data    = 8'h11;
    bus.host_valid   = 1'b1;
    #1;
    check("drop_ready", bus.host_ready, 1);
    tick();
    bus.host_valid = 1'b0;
    check("drop_no_wr", bus.fb_write_signal, 0);
    check("drop_one", drop_count, 1);
    bus.pix_address = 19'h4B000;
    bus.pix_valid   = 1'b1;
    repeat (299) tick();
    check("drop_sat", drop_count, 32'hFF);
    // Dropped pix requests still moved the pointer to pix, so host wins the tie.
    bus.pix_address  = 19'd3;
    bus.pix_data     = 8'h33;
    bus.host_address = 19'd4;
    bus.host_data    = 8'h44;
    bus.host_valid   = 1'b1;
    #1;
    check("tie_host_ready", bus.host_ready, 1);
    check("tie_pix_ready", bus.pix_ready, 0);
    tick();
    bus.pix_valid  = 1'b0;
    bus.host_valid = 1'b0;
    check("tie_wr", bus.fb_write_signal, 1);
    check("tie_addr", bus.fb_write_address, 4);
    check("tie_data", bus.fb_write_data, 32'h44);
    tick();

`ifdef FB_ARB_FILL_EN
    // Fill wins over a simultaneous pix request; pix is served after fill_done.
    fill_color      = 8'h1C;
    fill_start      = 1'b1;
    bus.pix_address = 19'd7;
    bus.pix_data    = 8'h99;
    bus.pix_valid   = 1'b1;
    #1;
    check("fill_wins_ready", bus.pix_ready, 0);
    tick();
    fill_start = 1'b0;
    busy_n = 0; done_n = 0; fidx = 0; viol = 0; got_pix = 1'b0; prev_wr = 1'b0; p_acc = 1'b0;
    for (int c = 0; c < 2 * FbWords + 8 && !got_pix; c++) begin
      if (p_acc) bus.pix_valid = 1'b0;
      if (fill_busy) busy_n++;
      if (fill_done) done_n++;
      if (bus.fb_write_signal) begin
        check("fill_no_b2b", prev_wr, 0);
        if (fill_busy) begin
          check("fill_addr", bus.fb_write_address, fidx);
          check("fill_data", bus.fb_write_data, 32'h1C);
          fidx++;
        end else begin
          check("fill_pix_addr", bus.fb_write_address, 7);
          check("fill_pix_data", bus.fb_write_data, 32'h99);
          got_pix = 1'b1;
        end
      end
      prev_wr = bus.fb_write_signal;
      #1;
      if (fill_busy && bus.pix_ready) viol++;
      p_acc = bus.pix_valid && bus.pix_ready;
      tick();
    end
    check("fill_busy_cycles", busy_n, 2 * FbWords);
    check("fill_writes", fidx, FbWords);
    check("fill_done_pulses", done_n, 1);
    check("fill_pix_blocked", viol, 0);
    check("fill_pix_issued", got_pix, 1);

    // Reset during the 5th fill write (address 4) aborts the fill for good.
    fill_color = 8'h3C;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus.fb_write_signal && bus.fb_write_address == 19'd4) seen = 1'b1;
      else tick();
    end
    check("rst_fill_reached", seen, 1);
    rst_n = 1'b0;
    tick();
    check("rstfill_wr", bus.fb_write_signal, 0);
    check("rstfill_addr", bus.fb_write_address, 0);
    check("rstfill_data", bus.fb_write_data, 0);
    check("rstfill_busy", fill_busy, 0);
    check("rstfill_done", fill_done, 0);
    check("rstfill_drop", drop_count, 0);
    rst_n = 1'b1;
    n5 = 0;
    repeat (2 * FbWords + 4) begin
      tick();
      if (bus.fb_write_signal) n5++;
    end
    check("rstfill_no_writes", n5, 0);
`else
    // Without the fill engine, fill_start is ignored entirely.
    fill_color      = 8'h1C;
    fill_start      = 1'b1;
    bus.pix_address = 19'd7;
    bus.pix_data    = 8'h99;
    bus.pix_valid   = 1'b1;
    #1;
    check("nofill_pix_ready", bus.pix_ready, 1);
    tick();
    fill_start    = 1'b0;
    bus.pix_valid = 1'b0;
    check("nofill_wr", bus.fb_write_signal, 1);
    check("nofill_addr", bus.fb_write_address, 7);
    check("nofill_data", bus.fb_write_data, 32'h99);
    check("nofill_busy", fill_busy, 0);
    check("nofill_done", fill_done, 0);
    tick();
`endif

    // Randomized traffic against the arbitration rules.
    for (int i = 0; i < NTxn; i++) begin
      pa[i] = pick_addr();
      ha[i] = pick_addr();
      pd[i] = 8'($urandom);
      hd[i] = 8'($urandom);
    end
    pulse_reset();
    pi = 0; hi = 0; drops = 0; exp_wr = 1'b0; last_host = 1'b1; p_acc = 1'b0; h_acc = 1'b0;
    exp_addr = '0; exp_data = '0;
    for (int c = 0; c < 600 && (pi < NTxn || hi < NTxn || exp_wr || p_acc || h_acc); c++) begin
      tick();
      exp_wr = 1'b0;
      if (p_acc || h_acc) begin
        a = h_acc ? ha[hi] : pa[pi];
        d = h_acc ? hd[hi] : pd[pi];
        if (a < FbWords) begin
          exp_wr   = 1'b1;
          exp_addr = a;
          exp_data = d;
        end else begin
          drops++;
        end
        last_host = h_acc;
        if (h_acc) begin
          hi++;
          bus.host_valid = 1'b0;
        end else begin
          pi++;
          bus.pix_valid = 1'b0;
        end
      end
      check("rnd_wr", bus.fb_write_signal, exp_wr);
      if (exp_wr) begin
        check("rnd_addr", bus.fb_write_address, exp_addr);
        check("rnd_data", bus.fb_write_data, exp_data);
      end
      if (!bus.pix_valid && pi < NTxn && $urandom_range(0, 2) != 0) begin
        bus.pix_valid   = 1'b1;
        bus.pix_address = pa[pi];
        bus.pix_data    = pd[pi];
      end
      if (!bus.host_valid && hi < NTxn && $urandom_range(0, 2) != 0) begin
        bus.host_valid   = 1'b1;
        bus.host_address = ha[hi];
        bus.host_data    = hd[hi];
      end
      #1;
      if (exp_wr) begin
        check("rnd_issue_pix_ready", bus.pix_ready, 0);
        check("rnd_issue_host_ready", bus.host_ready, 0);
      end else if (bus.pix_valid && bus.host_valid) begin
        check("rnd_tie_pix_ready", bus.pix_ready, last_host);
        check("rnd_tie_host_ready", bus.host_ready, !last_host);
      end else if (bus.pix_valid) begin
        check("rnd_solo_pix_ready", bus.pix_ready, 1);
      end else if (bus.host_valid) begin
        check("rnd_solo_host_ready", bus.host_ready, 1);
      end
      p_acc = bus.pix_valid && bus.pix_ready;
      h_acc = bus.host_valid && bus.host_ready;
    end
    check("rnd_all_done", (pi == NTxn) && (hi == NTxn), 1);
    check("rnd_drops", drop_count, (drops > 255) ? 255 : drops);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
